// File: rtl/md_unit_if.sv
// HI/LO unit bus: E-stage op/operands, flush, D-stage use flag and unit results.
interface md_unit_if;
  logic [3:0]  HILO_Op_E;
  logic        start_E;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        HILO_Use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] HILO_Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output HILO_Op_E, start_E, A, B, req, HILO_Use_D,
    input  busy, md_stall, HILO_Out, HI, LO
  );

  modport slave (
    input  HILO_Op_E, start_E, A, B, req, HILO_Use_D,
    output busy, md_stall, HILO_Out, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit: result computed at start, committed to HI/LO after a
// fixed latency modelled by a down-counter; raises a stall for D-stage HI/LO users.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [3:0]         op_q, op_d;
  logic               dz_q, dz_d;
  logic [31:0]        tmp_hi_q, tmp_hi_d;
  logic [31:0]        tmp_lo_q, tmp_lo_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               accept;
  logic [31:0]        divisor;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;
  logic [31:0]        res_hi, res_lo;

  // Result datapath: evaluated from this cycle's operands, latched on accept.
  // A zero divisor is replaced by 1 to keep the dividers defined; the commit is skipped anyway.
  always_comb begin
    divisor = (bus.B == '0) ? 32'd1 : bus.B;
    prod_s  = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u  = {32'd0, bus.A} * {32'd0, bus.B};
    if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
      quo_s = 32'h8000_0000;
      rem_s = '0;
    end else begin
      quo_s = $signed(bus.A) / $signed(divisor);
      rem_s = $signed(bus.A) % $signed(divisor);
    end
    quo_u = bus.A / divisor;
    rem_u = bus.A % divisor;
    res_hi = '0;
    res_lo = '0;
    case (bus.HILO_Op_E)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   begin res_hi = rem_s; res_lo = quo_s; end
      OP_DIVU:  begin res_hi = rem_u; res_lo = quo_u; end
      default:  ;
    endcase
  end

  // Sequencer next state: accept/count/commit plus mthi/mtlo writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    op_d     = op_q;
    dz_d     = dz_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    accept   = bus.start_E & ~bus.req & ~busy_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          op_d     = bus.HILO_Op_E;
          dz_d     = (bus.B == '0);
          tmp_hi_d = res_hi;
          tmp_lo_d = res_lo;
          cnt_d    = (bus.HILO_Op_E == OP_MULT || bus.HILO_Op_E == OP_MULTU)
                     ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (~bus.req && bus.HILO_Op_E == OP_MTHI) begin
          hi_d = bus.A;
        end else if (~bus.req && bus.HILO_Op_E == OP_MTLO) begin
          lo_d = bus.A;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (!(dz_q && (op_q == OP_DIV || op_q == OP_DIVU))) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      op_q     <= '0;
      dz_q     <= 1'b0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      op_q     <= op_d;
      dz_q     <= dz_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Read port and stall request, both combinational.
  always_comb begin
    case (bus.HILO_Op_E)
      OP_MFHI: bus.HILO_Out = hi_q;
      OP_MFLO: bus.HILO_Out = lo_q;
      default: bus.HILO_Out = '0;
    endcase
    bus.md_stall = bus.HILO_Use_D & (busy_q | bus.start_E);
    bus.busy     = busy_q;
    bus.HI       = hi_q;
    bus.LO       = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against an arithmetic HI/LO reference model.
module tb_md_unit;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference: HI/LO after an op, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, b,
                                             input logic [31:0] hi, lo);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          q, r;
    longint unsigned uq, ur;
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return 64'(ua * ub);
      4'd3: begin
        if (b == 0) return {hi, lo};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return {hi, lo};
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op <= 4'd2) ? 5 : 10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.HILO_Op_E = '0;
    bus.start_E   = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.req       = 1'b0;
  endtask

  // Drive a multi-cycle op, optionally pulsing req or a new start during RUN; returns busy cycles.
  task automatic do_md(input logic [3:0] op, input logic [31:0] a, b,
                       input int req_cyc, input int restart_cyc, output int n_busy);
    bus.HILO_Op_E = op; bus.start_E = 1'b1; bus.A = a; bus.B = b; bus.req = 1'b0;
    tick();
    n_busy = 0;
    while (bus.busy === 1'b1 && n_busy < 100) begin
      bus.req = (n_busy == req_cyc);
      if (n_busy == restart_cyc) begin
        bus.HILO_Op_E = 4'd2; bus.start_E = 1'b1; bus.A = $urandom; bus.B = $urandom;
      end else begin
        bus.HILO_Op_E = '0; bus.start_E = 1'b0;
      end
      n_busy++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    bus.HILO_Op_E = op; bus.A = v;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    bus.HILO_Use_D = 1'b0;
    tick(); tick();
    bus.HILO_Op_E = 4'd1; bus.start_E = 1'b1; bus.HILO_Use_D = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", bus.HI, bus.LO); end
    checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", bus.md_stall); end
    bus.HILO_Op_E = 4'd5; bus.start_E = 1'b0;
    #1;
    checks++; if (bus.HILO_Out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.HILO_Out); end
    clear_inputs();
    bus.HILO_Use_D = 1'b0;
    reset = 1'b1;
    tick();
    mhi = '0; mlo = '0;
  endtask

  task automatic test_directed(input string name, input logic [3:0] op, input logic [31:0] a, b);
    int n;
    {mhi, mlo} = ref_result(op, a, b, mhi, mlo);
    do_md(op, a, b, -1, -1, n);
    checks++; if (n != exp_lat(op)) begin errors++; $display("FAIL %s_busy: got %0d expected %0d", name, n, exp_lat(op)); end
    checks++; if (bus.HI !== mhi || bus.LO !== mlo) begin errors++; $display("FAIL %s_hilo: got %h/%h expected %h/%h", name, bus.HI, bus.LO, mhi, mlo); end
  endtask

  task automatic test_spec_vectors();
    test_directed("mult", 4'd1, 32'hFFFF_FFFF, 32'd2);
    checks++; if (mhi !== 32'hFFFF_FFFF || mlo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_model: got %h/%h expected ffffffff/fffffffe", mhi, mlo); end
    test_directed("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
    bus.HILO_Op_E = 4'd5; #1;
    checks++; if (bus.HILO_Out !== 32'h0000_0001) begin errors++; $display("FAIL multu_mfhi: got %h expected 00000001", bus.HILO_Out); end
    clear_inputs();
    test_directed("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
    checks++; if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_const: got %h/%h expected ffffffff/fffffffd", bus.HI, bus.LO); end
    test_directed("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    move_to(4'd7, 32'h11); mhi = 32'h11;
    move_to(4'd8, 32'h22); mlo = 32'h22;
    test_directed("divu_zero", 4'd4, 32'h1234_5678, 32'd0);
    checks++; if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin errors++; $display("FAIL divu_zero_const: got %h/%h expected 11/22", bus.HI, bus.LO); end
  endtask

  task automatic test_mthi_mtlo();
    move_to(4'd7, 32'hCAFE_0001); mhi = 32'hCAFE_0001;
    bus.HILO_Op_E = 4'd5; #1;
    checks++; if (bus.HILO_Out !== mhi) begin errors++; $display("FAIL mthi_read: got %h expected %h", bus.HILO_Out, mhi); end
    clear_inputs();
    move_to(4'd8, 32'hBEEF_0002); mlo = 32'hBEEF_0002;
    bus.HILO_Op_E = 4'd6; #1;
    checks++; if (bus.HILO_Out !== mlo) begin errors++; $display("FAIL mtlo_read: got %h expected %h", bus.HILO_Out, mlo); end
    bus.HILO_Op_E = 4'd9; #1;
    checks++; if (bus.HILO_Out !== 32'd0) begin errors++; $display("FAIL out_none: got %h expected 0", bus.HILO_Out); end
    clear_inputs();
  endtask

  task automatic test_flush();
    bus.HILO_Op_E = 4'd1; bus.start_E = 1'b1; bus.A = 32'h7; bus.B = 32'h9; bus.req = 1'b1;
    tick();
    clear_inputs();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
    bus.HILO_Op_E = 4'd7; bus.A = 32'hDEAD_BEEF; bus.req = 1'b1;
    tick();
    clear_inputs();
    repeat (6) tick();
    checks++; if (bus.HI !== mhi || bus.LO !== mlo) begin errors++; $display("FAIL flush_hilo: got %h/%h expected %h/%h", bus.HI, bus.LO, mhi, mlo); end
  endtask

  task automatic test_req_during_run();
    int n;
    {mhi, mlo} = ref_result(4'd3, 32'd1000, 32'd7, mhi, mlo);
    do_md(4'd3, 32'd1000, 32'd7, 4, -1, n);
    checks++; if (n != 10) begin errors++; $display("FAIL req_run_busy: got %0d expected 10", n); end
    checks++; if (bus.HI !== mhi || bus.LO !== mlo) begin errors++; $display("FAIL req_run_hilo: got %h/%h expected %h/%h", bus.HI, bus.LO, mhi, mlo); end
  endtask

  task automatic test_start_during_busy();
    int n;
    {mhi, mlo} = ref_result(4'd4, 32'hFFFF_0000, 32'd3, mhi, mlo);
    do_md(4'd4, 32'hFFFF_0000, 32'd3, -1, 3, n);
    checks++; if (n != 10) begin errors++; $display("FAIL restart_busy: got %0d expected 10", n); end
    checks++; if (bus.HI !== mhi || bus.LO !== mlo) begin errors++; $display("FAIL restart_hilo: got %h/%h expected %h/%h", bus.HI, bus.LO, mhi, mlo); end
  endtask

  task automatic test_mid_reset();
    move_to(4'd7, 32'h55);
    move_to(4'd8, 32'h66);
    bus.HILO_Op_E = 4'd3; bus.start_E = 1'b1; bus.A = 32'd100; bus.B = 32'd3;
    tick();
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mhi = '0; mlo = '0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin errors++; $display("FAIL midreset_hilo: got %h/%h expected 0/0", bus.HI, bus.LO); end
    repeat (12) tick();
    checks++; if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin errors++; $display("FAIL midreset_discard: got %b %h/%h expected 0 0/0", bus.busy, bus.HI, bus.LO); end
  endtask

  task automatic test_stall();
    {mhi, mlo} = ref_result(4'd1, 32'd12345, 32'hFFFF_FF00, mhi, mlo);
    bus.HILO_Use_D = 1'b1;
    bus.HILO_Op_E = 4'd1; bus.start_E = 1'b1; bus.A = 32'd12345; bus.B = 32'hFFFF_FF00;
    #1;
    checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL stall_start: got %b expected 1", bus.md_stall); end
    tick();
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.busy !== 1'b1 || bus.md_stall !== 1'b1) begin errors++; $display("FAIL stall_busy%0d: got busy=%b stall=%b expected 1/1", k, bus.busy, bus.md_stall); end
      tick();
    end
    checks++; if (bus.busy !== 1'b0 || bus.md_stall !== 1'b0) begin errors++; $display("FAIL stall_after: got busy=%b stall=%b expected 0/0", bus.busy, bus.md_stall); end
    checks++; if (bus.HI !== mhi || bus.LO !== mlo) begin errors++; $display("FAIL stall_hilo: got %h/%h expected %h/%h", bus.HI, bus.LO, mhi, mlo); end
    bus.HILO_Use_D = 1'b0;
  endtask

  task automatic test_back_to_back();
    test_directed("b2b_a", 4'd2, 32'hDEAD_BEEF, 32'h0000_1234);
    test_directed("b2b_b", 4'd3, 32'h8000_0001, 32'h0000_0010);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, v;
    int          n;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom;
        if ($urandom_range(0, 1) == 0) begin move_to(4'd7, v); mhi = v; end
        else begin move_to(4'd8, v); mlo = v; end
      end
      op = 4'($urandom_range(1, 4));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      {mhi, mlo} = ref_result(op, a, b, mhi, mlo);
      do_md(op, a, b, -1, -1, n);
      checks++; if (n != exp_lat(op)) begin errors++; $display("FAIL rnd%0d_busy op=%0d: got %0d expected %0d", i, op, n, exp_lat(op)); end
      bus.HILO_Op_E = 4'd5; #1;
      checks++; if (bus.HILO_Out !== mhi) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.HILO_Out, mhi); end
      bus.HILO_Op_E = 4'd6; #1;
      checks++; if (bus.HILO_Out !== mlo) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.HILO_Out, mlo); end
      clear_inputs();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_mthi_mtlo();
    test_flush();
    test_req_during_run();
    test_start_during_busy();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
